// File: rtl/sim_run_ctrl_if.sv
// rtl/sim_run_ctrl_if.sv - dump stream port of the run controller
interface sim_run_ctrl_if #(
  parameter int XLEN = 32
) ();
  logic            dump_valid;
  logic            dump_ready;
  logic [XLEN-1:0] dump_data;
  logic            dump_last;

  modport master (output dump_valid, output dump_data, output dump_last, input dump_ready);
  modport slave  (input dump_valid, input dump_data, input dump_last, output dump_ready);
endinterface

// File: rtl/sim_run_ctrl.sv
// rtl/sim_run_ctrl.sv - core reset sequencing, run timeout, tohost snoop and result dump
module sim_run_ctrl #(
  parameter int          XLEN         = 32,
  parameter int          ADDR_W       = 30,
  parameter int          NREGS        = 32,
  parameter int          RESET_CYCLES = 10,
  parameter int          MAX_CYCLES   = 100,
  parameter int          CNT_W        = 32,
  parameter [ADDR_W-1:0] TOHOST_ADDR  = 30'h400,
  parameter int          HEADER       = 1,
  localparam int         RA_W         = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              cpu_rst,
  output logic              cpu_halt,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_write,
  input  logic [XLEN-1:0]   mem_write_data,
  output logic [RA_W-1:0]   rf_rd_addr,
  input  logic [XLEN-1:0]   rf_rd_data,
  sim_run_ctrl_if.master    dump,
  output logic              done,
  output logic [1:0]        status,
  output logic [CNT_W-1:0]  cycle_count
);

  localparam int HOFF  = (HEADER != 0) ? 2 : 0;
  localparam int NW    = HOFF + NREGS;
  localparam int IDX_W = $clog2(NW + 1);
  localparam int RC_W  = $clog2(RESET_CYCLES + 1);

  localparam logic [1:0] ST_PASS    = 2'd1;
  localparam logic [1:0] ST_FAIL    = 2'd2;
  localparam logic [1:0] ST_TIMEOUT = 2'd3;

  typedef enum logic [1:0] {S_RST_HOLD, S_RUN, S_DUMP, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [RC_W-1:0]  rst_cnt;
  logic             p_valid;
  logic [IDX_W-1:0] p_idx;
  logic [XLEN-1:0]  cnt_word;
  logic [XLEN-1:0]  word;

  logic hold_done, halt_store, timeout, out_free, xfer_last;

  assign hold_done  = (rst_cnt == RC_W'(RESET_CYCLES - 1));
  assign halt_store = mem_write && (mem_addr == TOHOST_ADDR);
  assign timeout    = (cycle_count == CNT_W'(MAX_CYCLES));
  assign out_free   = !dump.dump_valid || dump.dump_ready;
  assign xfer_last  = dump.dump_valid && dump.dump_ready && dump.dump_last;

  generate
    if (CNT_W >= XLEN) begin : g_cnt_trunc
      assign cnt_word = cycle_count[XLEN-1:0];
    end else begin : g_cnt_ext
      assign cnt_word = {{(XLEN-CNT_W){1'b0}}, cycle_count};
    end
  endgenerate

  // Header slots bypass the regfile; register slots take the read issued last cycle.
  always_comb begin
    word = rf_rd_data;
    if (HEADER != 0 && p_idx == IDX_W'(0)) word = {{(XLEN-2){1'b0}}, status};
    else if (HEADER != 0 && p_idx == IDX_W'(1)) word = cnt_word;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_RST_HOLD;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST_HOLD: if (hold_done) state_d = S_RUN;
      S_RUN:      if (halt_store || timeout) state_d = S_DUMP;
      S_DUMP:     if (xfer_last) state_d = S_DONE;
      default:    state_d = state_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cpu_rst         <= 1'b1;
      cpu_halt        <= 1'b0;
      rf_rd_addr      <= '0;
      dump.dump_valid <= 1'b0;
      dump.dump_data  <= '0;
      dump.dump_last  <= 1'b0;
      done            <= 1'b0;
      status          <= 2'd0;
      cycle_count     <= '0;
      rst_cnt         <= '0;
      p_valid         <= 1'b0;
      p_idx           <= '0;
    end else begin
      case (state_q)
        S_RST_HOLD: begin
          if (hold_done) cpu_rst <= 1'b0;
          else           rst_cnt <= rst_cnt + RC_W'(1);
        end
        S_RUN: begin
          // A halt store in the timeout cycle still reports PASS/FAIL.
          if (halt_store || timeout) begin
            if (halt_store) status <= (mem_write_data == XLEN'(1)) ? ST_PASS : ST_FAIL;
            else            status <= ST_TIMEOUT;
            cpu_halt   <= 1'b1;
            p_valid    <= 1'b1;
            p_idx      <= '0;
            rf_rd_addr <= '0;
          end else begin
            cycle_count <= cycle_count + CNT_W'(1);
          end
        end
        S_DUMP: begin
          if (out_free) begin
            dump.dump_valid <= p_valid;
            dump.dump_last  <= p_valid && (p_idx == IDX_W'(NW - 1));
            if (p_valid) begin
              dump.dump_data <= word;
              if (p_idx == IDX_W'(NW - 1)) begin
                p_valid <= 1'b0;
              end else begin
                p_idx <= p_idx + IDX_W'(1);
                if (p_idx >= IDX_W'(HOFF)) rf_rd_addr <= rf_rd_addr + RA_W'(1);
              end
            end
          end
          if (xfer_last) done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
